memory_rsp_decoalesce_unit: RTL and testbench

- Response-side counterpart of the LD/ST command coalescer in the CGRA core.
- Accepts one cache-line response per coalesced command: load data plus tid bitmap and per-lane byte-offset map.
- Scatters load data into per-thread writebacks, one thread per cycle, ordered by ascending TID.
- Store responses produce a single one-cycle acknowledge carrying the bitmap.

---
 rtl/memory_rsp_decoalesce_unit.sv | 150 +++++++++++++++
 tb/tb_memory_rsp_decoalesce_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_rsp_decoalesce_unit.sv
// Scatters one coalesced cache-line load response into per-thread writebacks (ascending TID) and acks stores.
// Optional macro LOAD_SIGN_EXT_EN adds inrsp_sign_ext for sign-extended load data.
module memory_rsp_decoalesce_unit #(
    parameter int cache_line_size                  = 32,
    parameter int number_of_max_coalesced_commands = 8,
    parameter int base_address_offset              = $clog2(cache_line_size),
    parameter int base_tid_address_offset          = $clog2(number_of_max_coalesced_commands)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clear,
    input  logic                                   inrsp_valid,
    output logic                                   inrsp_ready,
    input  logic [3:0]                             inrsp_block_id,
    input  logic [9:0]                             inrsp_base_tid,
    input  logic [number_of_max_coalesced_commands-1:0] inrsp_tid_bitmap,
    input  logic                                   inrsp_write_enable,
    input  logic [cache_line_size*8-1:0]           inrsp_data,
    input  logic [1:0]                             inrsp_size,
    input  logic [6:0]                             inrsp_ld_dest_reg,
    input  logic [number_of_max_coalesced_commands-1:0][base_address_offset-1:0] inrsp_address_map,
`ifdef LOAD_SIGN_EXT_EN
    input  logic                                   inrsp_sign_ext,
`endif
    output logic                                   wb_valid,
    input  logic                                   wb_ready,
    output logic [3:0]                             wb_block_id,
    output logic [9:0]                             wb_tid,
    output logic [6:0]                             wb_ld_dest_reg,
    output logic [1:0]                             wb_size,
    output logic [63:0]                            wb_data,
    output logic                                   st_ack_valid,
    output logic [3:0]                             st_ack_block_id,
    output logic [9:0]                             st_ack_base_tid,
    output logic [number_of_max_coalesced_commands-1:0] st_ack_tid_bitmap,
    output logic                                   busy
);
    localparam int N  = number_of_max_coalesced_commands;
    localparam int LW = cache_line_size * 8;

    typedef enum logic [0:0] {IDLE, SCATTER} state_t;

    state_t                                   r_state, w_state_nxt;
    logic [3:0]                               r_block_id;
    logic [9:0]                               r_base_tid;
    logic [6:0]                               r_ld_dest_reg;
    logic [1:0]                               r_size;
    logic [LW-1:0]                            r_data;
    logic [N-1:0][base_address_offset-1:0]    r_map;
    logic [N-1:0]                             r_remaining;
    logic                                     r_sign_ext;

    logic                                     w_accept, w_load_go, w_beat;
    logic [base_tid_address_offset-1:0]       w_lane;
    logic [N-1:0]                             w_remaining_nxt;
    logic [63:0]                              w_raw, w_mask, w_ext;
    logic                                     w_sbit;

    assign inrsp_ready = (r_state == IDLE) && !clear;
    assign w_accept    = inrsp_valid && inrsp_ready;
    assign w_load_go   = w_accept && !inrsp_write_enable && (|inrsp_tid_bitmap);
    assign w_beat      = (r_state == SCATTER) && wb_ready;
    assign busy        = (r_state == SCATTER);
    assign wb_valid    = busy;

    always_comb begin
        w_lane = '0;
        for (int i = N - 1; i >= 0; i--)
            if (r_remaining[i]) w_lane = base_tid_address_offset'(i);
    end
    assign w_remaining_nxt = r_remaining & ~(N'(1) << w_lane);

    // Right shift zero-fills, so bytes past the end of the line read as 0.
    assign w_raw = 64'(r_data >> {r_map[w_lane], 3'b000});

    always_comb begin
        w_mask = 64'h0000_0000_0000_00FF;
        w_sbit = w_raw[7];
        case (r_size)
            2'd1:    begin w_mask = 64'h0000_0000_0000_FFFF; w_sbit = w_raw[15]; end
            2'd2:    begin w_mask = 64'h0000_0000_FFFF_FFFF; w_sbit = w_raw[31]; end
            2'd3:    begin w_mask = 64'hFFFF_FFFF_FFFF_FFFF; w_sbit = w_raw[63]; end
            default: ;
        endcase
        w_ext = (w_raw & w_mask) | ((r_sign_ext && w_sbit) ? ~w_mask : 64'h0);
    end

    assign wb_block_id    = busy ? r_block_id    : '0;
    assign wb_tid         = busy ? (r_base_tid | 10'(w_lane)) : '0;
    assign wb_ld_dest_reg = busy ? r_ld_dest_reg : '0;
    assign wb_size        = busy ? r_size        : '0;
    assign wb_data        = busy ? w_ext         : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear)
            w_state_nxt = IDLE;
        else if (r_state == IDLE && w_load_go)
            w_state_nxt = SCATTER;
        else if (w_beat && w_remaining_nxt == '0)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_block_id        <= '0;
            r_base_tid        <= '0;
            r_ld_dest_reg     <= '0;
            r_size            <= '0;
            r_data            <= '0;
            r_map             <= '0;
            r_remaining       <= '0;
            r_sign_ext        <= 1'b0;
            st_ack_valid      <= 1'b0;
            st_ack_block_id   <= '0;
            st_ack_base_tid   <= '0;
            st_ack_tid_bitmap <= '0;
        end else begin
            st_ack_valid <= 1'b0;
            if (clear) begin
                r_remaining <= '0;
            end else if (w_accept && inrsp_write_enable) begin
                st_ack_valid      <= 1'b1;
                st_ack_block_id   <= inrsp_block_id;
                st_ack_base_tid   <= inrsp_base_tid;
                st_ack_tid_bitmap <= inrsp_tid_bitmap;
            end else if (w_load_go) begin
                r_block_id    <= inrsp_block_id;
                r_base_tid    <= inrsp_base_tid;
                r_ld_dest_reg <= inrsp_ld_dest_reg;
                r_size        <= inrsp_size;
                r_data        <= inrsp_data;
                r_map         <= inrsp_address_map;
                r_remaining   <= inrsp_tid_bitmap;
`ifdef LOAD_SIGN_EXT_EN
                r_sign_ext    <= inrsp_sign_ext;
`else
                r_sign_ext    <= 1'b0;
`endif
            end else if (w_beat) begin
                r_remaining <= w_remaining_nxt;
            end
        end
    end
endmodule

// File: tb/tb_memory_rsp_decoalesce_unit.sv
// Scoreboard bench for memory_rsp_decoalesce_unit: expected writebacks/acks queued at send, checked at output.
module tb_memory_rsp_decoalesce_unit;
    logic            clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic            inrsp_valid = 1'b0, inrsp_ready;
    logic [3:0]      inrsp_block_id = '0;
    logic [9:0]      inrsp_base_tid = '0;
    logic [7:0]      inrsp_tid_bitmap = '0;
    logic            inrsp_write_enable = 1'b0;
    logic [255:0]    inrsp_data = '0;
    logic [1:0]      inrsp_size = '0;
    logic [6:0]      inrsp_ld_dest_reg = '0;
    logic [7:0][4:0] inrsp_address_map = '0;
    logic            inrsp_sign_ext = 1'b0;
    logic            wb_valid, wb_ready = 1'b1;
    logic [3:0]      wb_block_id;
    logic [9:0]      wb_tid;
    logic [6:0]      wb_ld_dest_reg;
    logic [1:0]      wb_size;
    logic [63:0]     wb_data;
    logic            st_ack_valid;
    logic [3:0]      st_ack_block_id;
    logic [9:0]      st_ack_base_tid;
    logic [7:0]      st_ack_tid_bitmap;
    logic            busy;

`ifdef LOAD_SIGN_EXT_EN
    localparam bit SX_EN = 1'b1;
`else
    localparam bit SX_EN = 1'b0;
`endif

    memory_rsp_decoalesce_unit dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .inrsp_valid(inrsp_valid), .inrsp_ready(inrsp_ready),
        .inrsp_block_id(inrsp_block_id), .inrsp_base_tid(inrsp_base_tid),
        .inrsp_tid_bitmap(inrsp_tid_bitmap), .inrsp_write_enable(inrsp_write_enable),
        .inrsp_data(inrsp_data), .inrsp_size(inrsp_size),
        .inrsp_ld_dest_reg(inrsp_ld_dest_reg), .inrsp_address_map(inrsp_address_map),
`ifdef LOAD_SIGN_EXT_EN
        .inrsp_sign_ext(inrsp_sign_ext),
`endif
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_block_id(wb_block_id),
        .wb_tid(wb_tid), .wb_ld_dest_reg(wb_ld_dest_reg), .wb_size(wb_size),
        .wb_data(wb_data), .st_ack_valid(st_ack_valid),
        .st_ack_block_id(st_ack_block_id), .st_ack_base_tid(st_ack_base_tid),
        .st_ack_tid_bitmap(st_ack_tid_bitmap), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [3:0] bid; logic [9:0] tid; logic [6:0] dst; logic [1:0] sz; logic [63:0] data; } wb_exp_t;
    typedef struct packed { logic [3:0] bid; logic [9:0] btid; logic [7:0] bm; } st_exp_t;
    wb_exp_t wq[$];
    st_exp_t sq[$];

    int n_chk = 0, n_pass = 0, n_wb = 0, n_st = 0, last_wait = 0;
    logic [255:0]    line;
    logic [7:0][4:0] mp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] model(input logic [255:0] ln, input logic [4:0] off,
                                          input logic [1:0] sz, input logic sx);
        int nb = 1 << sz;
        int idx;
        logic [63:0] r = '0;
        for (int i = 0; i < nb; i++) begin
            idx = int'(off) + i;
            if (idx < 32) r[i*8 +: 8] = ln[idx*8 +: 8];
        end
        if (SX_EN && sx && r[nb*8-1])
            for (int i = nb * 8; i < 64; i++) r[i] = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Caller is just past a rising edge; the response is accepted at the next ready edge.
    task automatic send(input logic we, input logic [3:0] bid, input logic [9:0] btid,
                        input logic [7:0] bm, input logic [1:0] sz, input logic sx);
        int w = 0;
        inrsp_valid = 1'b1; inrsp_write_enable = we; inrsp_block_id = bid;
        inrsp_base_tid = btid; inrsp_tid_bitmap = bm; inrsp_size = sz;
        inrsp_ld_dest_reg = 7'(btid) ^ 7'h2A; inrsp_data = line;
        inrsp_address_map = mp; inrsp_sign_ext = sx;
        @(negedge clk);
        while (!inrsp_ready && w < 50) begin @(negedge clk); w++; end
        last_wait = w;
        chk("accept_ready", {63'b0, inrsp_ready}, 64'd1);
        if (we) sq.push_back('{bid, btid, bm});
        else
            for (int l = 0; l < 8; l++)
                if (bm[l]) wq.push_back('{bid, btid | 10'(l), 7'(btid) ^ 7'h2A, sz, model(line, mp[l], sz, sx)});
        @(posedge clk); #1;
        inrsp_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while (busy && c < 100) begin @(negedge clk); c++; end
        chk("idle_timeout", {63'b0, busy}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid && wb_ready) begin
            wb_exp_t e;
            n_wb++;
            if (wq.size() == 0) chk("wb_unexpected", 64'd1, 64'd0);
            else begin
                e = wq.pop_front();
                chk("wb_tid", {54'b0, wb_tid}, {54'b0, e.tid});
                chk("wb_data", wb_data, e.data);
                chk("wb_meta", {51'b0, wb_block_id, wb_ld_dest_reg, wb_size},
                               {51'b0, e.bid, e.dst, e.sz});
            end
        end
        if (rst_n && st_ack_valid) begin
            st_exp_t s;
            n_st++;
            if (sq.size() == 0) chk("st_unexpected", 64'd1, 64'd0);
            else begin
                s = sq.pop_front();
                chk("st_ack", {42'b0, st_ack_block_id, st_ack_base_tid, st_ack_tid_bitmap},
                              {42'b0, s.bid, s.btid, s.bm});
            end
        end
    end

    initial begin
        int b0;
        for (int k = 0; k < 32; k++) line[k*8 +: 8] = 8'(k);
        mp = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {63'b0, inrsp_ready}, 64'd1);
        chk("rst_outs", {60'b0, wb_valid, st_ack_valid, busy, |wb_tid}, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // two-lane word load
        mp[0] = 5'd4; mp[2] = 5'd12;
        b0 = n_wb;
        send(1'b0, 4'h3, 10'h010, 8'h05, 2'd2, 1'b0);
        @(negedge clk);
        chk("lat_wb_valid", {63'b0, wb_valid}, 64'd1);
        chk("lat_first", wb_data, 64'h0706_0504);
        wait_idle();
        chk("beats_2", 64'(n_wb - b0), 64'd2);

        // backpressure on first beat
        step(); wb_ready = 1'b0;
        send(1'b0, 4'h3, 10'h010, 8'h05, 2'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold", {53'b0, wb_valid, wb_tid}, {53'b0, 1'b1, 10'h010});
            chk("bp_data", wb_data, 64'h0706_0504);
            chk("bp_ready", {63'b0, inrsp_ready}, 64'd0);
        end
        step(); wb_ready = 1'b1;
        wait_idle();

        // store
        step(); b0 = n_st;
        send(1'b1, 4'h5, 10'h020, 8'hFF, 2'd0, 1'b0);
        @(negedge clk);
        chk("st_side", {61'b0, inrsp_ready, wb_valid, busy}, {61'b0, 3'b100});
        @(negedge clk);
        chk("st_one_cycle", {63'b0, st_ack_valid}, 64'd0);
        chk("st_count", 64'(n_st - b0), 64'd1);

        // line-end boundary and halfword loads
        mp = '0; mp[7] = 5'd28;
        step(); send(1'b0, 4'h7, 10'h030, 8'h80, 2'd3, 1'b0);
        @(negedge clk);
        chk("edge_data", wb_data, 64'h0000_0000_1F1E_1D1C);
        wait_idle();
        mp = '0; mp[1] = 5'd31; mp[4] = 5'd0;
        step(); send(1'b0, 4'h1, 10'h040, 8'h12, 2'd1, 1'b0);
        wait_idle();

        // empty-bitmap load is dropped
        step(); b0 = n_wb;
        send(1'b0, 4'h2, 10'h050, 8'h00, 2'd2, 1'b0);
        @(negedge clk);
        chk("drop_idle", {62'b0, busy, wb_valid}, 64'd0);
        @(negedge clk);
        chk("drop_no_wb", 64'(n_wb - b0), 64'd0);

        // clear mid-scatter with three lanes left
        for (int l = 0; l < 8; l++) mp[l] = 5'(4 * l);
        step(); send(1'b0, 4'h9, 10'h080, 8'h0F, 2'd2, 1'b0);
        step(); clear = 1'b1; wb_ready = 1'b0;
        @(negedge clk);
        chk("clr_ready", {63'b0, inrsp_ready}, 64'd0);
        chk("clr_left", 64'(wq.size()), 64'd3);
        step(); clear = 1'b0; wb_ready = 1'b1;
        chk("clr_state", {62'b0, wb_valid, busy}, 64'd0);
        wq.delete();
        send(1'b0, 4'hA, 10'h090, 8'h01, 2'd2, 1'b0);
        chk("clr_accept_next", 64'(last_wait), 64'd0);
        wait_idle();

        // byte load with the sign bit set
        line[7:0] = 8'h80; mp = '0;
        step(); send(1'b0, 4'hB, 10'h0A0, 8'h01, 2'd0, 1'b1);
        @(negedge clk);
        chk("sx_on", wb_data, SX_EN ? 64'hFFFF_FFFF_FFFF_FF80 : 64'h80);
        wait_idle();
        step(); send(1'b0, 4'hB, 10'h0A0, 8'h01, 2'd0, 1'b0);
        @(negedge clk);
        chk("sx_off", wb_data, 64'h80);
        wait_idle();

        repeat (3) @(negedge clk);
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("sq_empty", 64'(sq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
